// File: rtl/mux_arb_2x1.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// Optional packet locking is compiled in with MUX_ARB_2X1_LOCK_EN.
module mux_arb_2x1 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] b,
  input  logic         b_valid,
  output logic         b_ready,
`ifdef MUX_ARB_2X1_LOCK_EN
  input  logic         a_last,
  input  logic         b_last,
  output logic         y_last,
`endif
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         sl_1
);

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic last_gnt;
  logic free_c;
  logic allow_a;
  logic allow_b;
  logic elig_a;
  logic elig_b;
  logic grant_a;
  logic grant_b;
  logic accept;

`ifdef MUX_ARB_2X1_LOCK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A non-last beat opens a packet; the last beat of the locked source closes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_a && !a_last) begin
          state_nxt = LOCK_A;
        end else if (grant_b && !b_last) begin
          state_nxt = LOCK_B;
        end
      end
      LOCK_A:  if (grant_a && a_last) state_nxt = IDLE;
      LOCK_B:  if (grant_b && b_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Locked state masks the other source out of arbitration
  always_comb begin
    allow_a = 1'b1;
    allow_b = 1'b1;
    case (state)
      LOCK_A:  allow_b = 1'b0;
      LOCK_B:  allow_a = 1'b0;
      default: ;
    endcase
  end
`else
  assign allow_a = 1'b1;
  assign allow_b = 1'b1;
`endif

  // Arbitration: ready never looks at data, only handshakes and state
  always_comb begin
    free_c  = !y_valid || y_ready;
    elig_a  = a_valid && free_c && allow_a;
    elig_b  = b_valid && free_c && allow_b;
    grant_a = elig_a && (!elig_b || (last_gnt == SEL_B));
    grant_b = elig_b && !grant_a;
    accept  = grant_a || grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Output stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      y_valid  <= 1'b0;
      sl_1     <= SEL_A;
      last_gnt <= SEL_B;
`ifdef MUX_ARB_2X1_LOCK_EN
      y_last   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        y        <= grant_b ? b : a;
        y_valid  <= 1'b1;
        sl_1     <= grant_b ? SEL_B : SEL_A;
        last_gnt <= grant_b ? SEL_B : SEL_A;
`ifdef MUX_ARB_2X1_LOCK_EN
        y_last   <= grant_b ? b_last : a_last;
`endif
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Directed self-checking bench for mux_arb_2x1; inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_mux_arb_2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       sl_1;
`ifdef MUX_ARB_2X1_LOCK_EN
  logic       a_last;
  logic       b_last;
  logic       y_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arb_2x1 #(.W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
`ifdef MUX_ARB_2X1_LOCK_EN
    .a_last  (a_last),
    .b_last  (b_last),
    .y_last  (y_last),
`endif
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sl_1    (sl_1)
  );

  task automatic test_reset();
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %b want 0", y_valid); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rst_y got %h want 00", y); end
    checks++; if (sl_1 !== 1'b0) begin errors++; $display("FAIL rst_sl_1 got %b want 0", sl_1); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {a_ready, b_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_y [4];
    logic       exp_s [4];
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h11; exp_y[3] = 8'h22;
    exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;
    @(negedge clk);
    a = 8'h11; b = 8'h22; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL rr_first_tie got %b want 10", {a_ready, b_ready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (y !== exp_y[i]) begin errors++; $display("FAIL rr_y%0d got %h want %h", i, y, exp_y[i]); end
      checks++; if (sl_1 !== exp_s[i]) begin errors++; $display("FAIL rr_sl%0d got %b want %b", i, sl_1, exp_s[i]); end
      checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d got %b want 1", i, y_valid); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", y_valid); end
    checks++; if (y !== 8'h22 || sl_1 !== 1'b1) begin errors++; $display("FAIL rr_hold got %h/%b want 22/1", y, sl_1); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({y_valid, a_ready, b_ready} !== 3'b000) begin errors++; $display("FAIL idle%0d got %b want 000", i, {y_valid, a_ready, b_ready}); end
    end
    // Last grant was B, so a tie probe must still favour A
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL idle_ptr got %b want 10", {a_ready, b_ready}); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    b = 8'h5A; b_valid = 1'b1; y_ready = 1'b0;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL bp_accept got %b want 01", {a_ready, b_ready}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) a_valid = 1'b1;
      #1;
      checks++; if (y !== 8'h5A || y_valid !== 1'b1 || sl_1 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %h/%b/%b want 5a/1/1", i, y, y_valid, sl_1); end
      checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", i, {a_ready, b_ready}); end
    end
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", y_valid); end
    // A's dropped request must not have moved the pointer off B
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL bp_ptr got %b want 10", {a_ready, b_ready}); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b = 8'h44; b_valid = 1'b1; y_ready = 1'b1;
    @(negedge clk);
    checks++; if (y !== 8'h44 || y_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want 44/1", y, y_valid); end
    b_valid = 1'b0; a = 8'h33; a_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ready got %b want 10", {a_ready, b_ready}); end
    @(negedge clk);
    checks++; if (y !== 8'h33 || y_valid !== 1'b1 || sl_1 !== 1'b0) begin errors++; $display("FAIL b2b_second got %h/%b/%b want 33/1/0", y, y_valid, sl_1); end
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", y_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b = 8'hEE; b_valid = 1'b1; y_ready = 1'b0;
    @(negedge clk);
    checks++; if (y !== 8'hEE || y_valid !== 1'b1 || sl_1 !== 1'b1) begin errors++; $display("FAIL rm_load got %h/%b/%b want ee/1/1", y, y_valid, sl_1); end
    b_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (y_valid !== 1'b0 || y !== 8'h00 || sl_1 !== 1'b0) begin errors++; $display("FAIL rm_async got %h/%b/%b want 00/0/0", y, y_valid, sl_1); end
    y_ready = 1'b1;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rm_discard got %b want 0", y_valid); end
    rst_n = 1'b1; a = 8'h71; b = 8'h72; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL rm_tie got %b want 10", {a_ready, b_ready}); end
    @(negedge clk);
    checks++; if (y !== 8'h71 || y_valid !== 1'b1 || sl_1 !== 1'b0) begin errors++; $display("FAIL rm_first got %h/%b/%b want 71/1/0", y, y_valid, sl_1); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rm_drain got %b want 0", y_valid); end
  endtask

`ifdef MUX_ARB_2X1_LOCK_EN
  task automatic test_lock();
    logic [7:0] exp_y [3];
    logic       exp_l [3];
    exp_y[0] = 8'hA1; exp_y[1] = 8'hA2; exp_y[2] = 8'hA3;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
    @(negedge clk);
    a = 8'hA1; a_last = 1'b0; a_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (y !== exp_y[i] || y_last !== exp_l[i] || sl_1 !== 1'b0) begin errors++; $display("FAIL lock_a%0d got %h/%b/%b want %h/%b/0", i, y, y_last, sl_1, exp_y[i], exp_l[i]); end
      if (i == 0) begin
        b = 8'hB1; b_last = 1'b0; b_valid = 1'b1; a = 8'hA2;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL lock_mask got %b want 10", {a_ready, b_ready}); end
      end else if (i == 1) begin
        a = 8'hA3; a_last = 1'b1;
      end else begin
        a_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (y !== 8'hB1 || y_last !== 1'b0 || sl_1 !== 1'b1) begin errors++; $display("FAIL lock_b got %h/%b/%b want b1/0/1", y, y_last, sl_1); end
    b_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
`ifdef MUX_ARB_2X1_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif
    test_reset();
    test_round_robin();
    test_idle();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef MUX_ARB_2X1_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
